pipelined_shift_unit: RTL and testbench

PIPELINED_SHIFT_UNIT -- requirements
Module: pipelined_shift_unit

---
 rtl/shift_pkg.sv | 44 ++++
 rtl/shift_stage.sv | 83 ++++++++
 rtl/pipelined_shift_unit.sv | 101 ++++++++++
 tb/tb_pipelined_shift_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the pipelined shift unit: op encodings, per-op control
// flags carried down the pipe, and the barrel-level split across stages.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b011,
        OP_ROL = 3'b100,
        OP_ROR = 3'b101
    } shift_op_e;

    // Left ops run as right ops on bit-reversed data, so only these flags travel.
    typedef struct packed {
        logic left;
        logic rot;
        logic arith;
        logic word;
        logic illegal;
    } shift_ctrl_t;

    function automatic int shamt_w(input int xlen);
        return $clog2(xlen);
    endfunction

    function automatic int lvl_per_stage(input int levels, input int stages);
        return (levels + stages - 1) / stages;
    endfunction

    function automatic int lvl_lo(input int stage, input int levels, input int stages);
        int lo;
        lo = stage * lvl_per_stage(levels, stages);
        return (lo > levels) ? levels : lo;
    endfunction

    // The last stage always ends at the top level and absorbs the remainder.
    function automatic int lvl_hi(input int stage, input int levels, input int stages);
        int hi;
        hi = (stage + 1) * lvl_per_stage(levels, stages);
        if (stage == stages - 1) return levels;
        return (hi > levels) ? levels : hi;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: applies barrel levels [LVL_LO, LVL_HI) and registers
// valid/data/amount/control/tag, advancing only on the global advance.
module shift_stage
    import shift_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 4,
    parameter int LVL_LO  = 0,
    parameter int LVL_HI  = 5,
    parameter bit FIRST   = 1'b0,
    parameter bit LAST    = 1'b0
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               i_adv,
    input  logic               i_flush,
    input  logic               i_vld,
    input  logic [XLEN-1:0]    i_data,
    input  logic [SHAMT_W-1:0] i_amt,
    input  shift_ctrl_t        i_ctrl,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_vld,
    output logic [XLEN-1:0]    o_data,
    output logic [SHAMT_W-1:0] o_amt,
    output shift_ctrl_t        o_ctrl,
    output logic [TAG_W-1:0]   o_tag
);

    logic [XLEN-1:0] w_data;
    logic [XLEN-1:0] w_fill;
    logic [31:0]     w_fill32;

    // Word mode reverses only the low word; the upper half is rebuilt at the end.
    function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] d, input logic word);
        logic [XLEN-1:0] r;
        for (int b = 0; b < XLEN; b++) r[b] = d[XLEN-1-b];
        if (word) for (int b = 0; b < 32; b++) r[b] = d[31-b];
        return r;
    endfunction

    always_comb begin
        w_data   = i_data;
        w_fill   = '0;
        w_fill32 = '0;
        if (FIRST && i_ctrl.left) w_data = bitrev(w_data, i_ctrl.word);
        for (int k = LVL_LO; k < LVL_HI; k++) begin
            if (i_amt[k]) begin
                if (i_ctrl.word) begin
                    w_fill32      = i_ctrl.rot ? w_data[31:0] : {32{i_ctrl.arith & w_data[31]}};
                    w_data[31:0]  = 32'({w_fill32, w_data[31:0]} >> (1 << k));
                end else begin
                    w_fill = i_ctrl.rot ? w_data : {XLEN{i_ctrl.arith & w_data[XLEN-1]}};
                    w_data = XLEN'({w_fill, w_data} >> (1 << k));
                end
            end
        end
        if (LAST) begin
            if (i_ctrl.left) w_data = bitrev(w_data, i_ctrl.word);
            if (i_ctrl.word) for (int b = 32; b < XLEN; b++) w_data[b] = w_data[31];
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            o_vld  <= 1'b0;
            o_data <= '0;
            o_amt  <= '0;
            o_ctrl <= '0;
            o_tag  <= '0;
        end else begin
            if (i_flush)    o_vld <= 1'b0;
            else if (i_adv) o_vld <= i_vld;
            if (i_adv) begin
                o_data <= w_data;
                o_amt  <= i_amt;
                o_ctrl <= i_ctrl;
                o_tag  <= i_tag;
            end
        end
    end

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined shifter/rotator with valid/ready handshake, tag sideband, flush
// and RV64 word mode; one op per cycle, fixed STAGES-cycle latency.
module pipelined_shift_unit
    import shift_pkg::*;
#(
    parameter int  XLEN    = 32,
    parameter int  STAGES  = 2,
    parameter int  TAG_W   = 4,
    localparam int SHAMT_W = shamt_w(XLEN)
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [XLEN-1:0]    Src1,
    input  logic [SHAMT_W-1:0] Src2,
    input  logic [2:0]         Op,
    input  logic               Word,
    input  logic [TAG_W-1:0]   In_Tag,
    input  logic               Flush,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [XLEN-1:0]    Result,
    output logic [TAG_W-1:0]   Out_Tag,
    output logic               Illegal
);

    logic                           w_adv;
    logic [XLEN-1:0]                w_src;
    logic [SHAMT_W-1:0]             w_amt_in;
    shift_ctrl_t                    w_ctrl_in;
    logic [STAGES:0]                w_vld_pipe;
    logic [STAGES:0][XLEN-1:0]      w_data_pipe;
    logic [STAGES:0][SHAMT_W-1:0]   w_amt_pipe;
    shift_ctrl_t [STAGES:0]         w_ctrl_pipe;
    logic [STAGES:0][TAG_W-1:0]     w_tag_pipe;
    logic                           w_unused;

    always_comb begin
        w_ctrl_in      = '0;
        w_src          = Src1;
        w_amt_in       = Src2;
        w_ctrl_in.word = (XLEN == 64) && Word;
        case (Op)
            OP_SLL:  w_ctrl_in.left  = 1'b1;
            OP_SRL:  ;
            OP_SRA:  w_ctrl_in.arith = 1'b1;
            OP_ROL:  begin w_ctrl_in.left = 1'b1; w_ctrl_in.rot = 1'b1; end
            OP_ROR:  w_ctrl_in.rot   = 1'b1;
            default: w_ctrl_in.illegal = 1'b1;
        endcase
        if (w_ctrl_in.word)    w_amt_in[SHAMT_W-1] = 1'b0;
        // A zero operand stays zero through every level, giving Result=0 for free.
        if (w_ctrl_in.illegal) w_src = '0;
    end

    assign w_adv    = !Out_Valid || Out_Ready;
    assign In_Ready = w_adv && !Flush;

    assign w_vld_pipe[0]  = In_Valid && In_Ready;
    assign w_data_pipe[0] = w_src;
    assign w_amt_pipe[0]  = w_amt_in;
    assign w_ctrl_pipe[0] = w_ctrl_in;
    assign w_tag_pipe[0]  = In_Tag;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        shift_stage #(
            .XLEN    (XLEN),
            .SHAMT_W (SHAMT_W),
            .TAG_W   (TAG_W),
            .LVL_LO  (lvl_lo(s, SHAMT_W, STAGES)),
            .LVL_HI  (lvl_hi(s, SHAMT_W, STAGES)),
            .FIRST   (s == 0),
            .LAST    (s == STAGES - 1)
        ) u_stage (
            .CLK     (CLK),
            .rst_n   (rst_n),
            .i_adv   (w_adv),
            .i_flush (Flush),
            .i_vld   (w_vld_pipe[s]),
            .i_data  (w_data_pipe[s]),
            .i_amt   (w_amt_pipe[s]),
            .i_ctrl  (w_ctrl_pipe[s]),
            .i_tag   (w_tag_pipe[s]),
            .o_vld   (w_vld_pipe[s+1]),
            .o_data  (w_data_pipe[s+1]),
            .o_amt   (w_amt_pipe[s+1]),
            .o_ctrl  (w_ctrl_pipe[s+1]),
            .o_tag   (w_tag_pipe[s+1])
        );
    end

    assign Out_Valid = w_vld_pipe[STAGES];
    assign Result    = w_data_pipe[STAGES];
    assign Out_Tag   = w_tag_pipe[STAGES];
    assign Illegal   = w_ctrl_pipe[STAGES].illegal;

    // Amount and direction flags are consumed inside the last stage.
    assign w_unused = ^{w_amt_pipe[STAGES], w_ctrl_pipe[STAGES]};

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Directed bench: 32-bit/2-stage instance for handshake, flush and reset cases,
// 64-bit/3-stage instance for word mode and wide shifts.
module tb_pipelined_shift_unit;

    logic        CLK = 1'b0;
    logic        rst_n;
    always #5 CLK = ~CLK;

    // XLEN=32, STAGES=2
    logic        iv, ir, flush, ov, ordy, ill, word;
    logic [31:0] src1, res;
    logic [4:0]  src2;
    logic [2:0]  op;
    logic [3:0]  itag, otag;

    // XLEN=64, STAGES=3
    logic        iv6, ir6, ov6, ill6, word6;
    logic [63:0] src1_6, res6;
    logic [5:0]  src2_6;
    logic [2:0]  op6;
    logic [3:0]  itag6, otag6;

    int n_chk  = 0;
    int n_pass = 0;

    pipelined_shift_unit #(.XLEN(32), .STAGES(2), .TAG_W(4)) dut32 (
        .CLK(CLK), .rst_n(rst_n), .In_Valid(iv), .In_Ready(ir), .Src1(src1), .Src2(src2),
        .Op(op), .Word(word), .In_Tag(itag), .Flush(flush), .Out_Valid(ov), .Out_Ready(ordy),
        .Result(res), .Out_Tag(otag), .Illegal(ill)
    );

    pipelined_shift_unit #(.XLEN(64), .STAGES(3), .TAG_W(4)) dut64 (
        .CLK(CLK), .rst_n(rst_n), .In_Valid(iv6), .In_Ready(ir6), .Src1(src1_6), .Src2(src2_6),
        .Op(op6), .Word(word6), .In_Tag(itag6), .Flush(1'b0), .Out_Valid(ov6), .Out_Ready(1'b1),
        .Result(res6), .Out_Tag(otag6), .Illegal(ill6)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic drv(input logic [2:0] o, input logic [31:0] s1, input logic [4:0] s2,
                       input logic [3:0] t);
        iv = 1'b1; op = o; src1 = s1; src2 = s2; itag = t;
    endtask

    task automatic drv6(input logic [2:0] o, input logic w, input logic [63:0] s1,
                        input logic [5:0] s2, input logic [3:0] t);
        iv6 = 1'b1; op6 = o; word6 = w; src1_6 = s1; src2_6 = s2; itag6 = t;
    endtask

    logic [2:0]  b_op  [3] = '{3'b011, 3'b101, 3'b100};
    logic [31:0] b_src [3] = '{32'hABCD_FFFF, 32'h8000_0001, 32'h8000_0001};
    logic [4:0]  b_sh  [3] = '{5'd3, 5'd1, 5'd4};
    logic [31:0] b_exp [3] = '{32'hF579_BFFF, 32'hC000_0000, 32'h0000_0018};

    localparam int N6 = 7;
    logic [2:0]  w_op  [N6] = '{3'b000, 3'b011, 3'b011, 3'b101, 3'b101, 3'b001, 3'b100};
    logic        w_wd  [N6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] w_src [N6] = '{64'h0000_0000_4000_0000, 64'h0000_0000_4000_0000,
                                64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001,
                                64'h0000_0000_0000_0001, 64'hFFFF_FFFF_7FFF_FFFF,
                                64'h8000_0000_0000_0001};
    logic [5:0]  w_sh  [N6] = '{6'd1, 6'd33, 6'd4, 6'd1, 6'd1, 6'd0, 6'd4};
    logic [63:0] w_exp [N6] = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_2000_0000,
                                64'hF800_0000_0000_0000, 64'h8000_0000_0000_0000,
                                64'hFFFF_FFFF_8000_0000, 64'h0000_0000_7FFF_FFFF,
                                64'h0000_0000_0000_0018};

    initial begin
        rst_n = 1'b0; iv = 0; flush = 0; ordy = 1; word = 0; op = 0; src1 = 0; src2 = 0; itag = 0;
        iv6 = 0; word6 = 0; op6 = 0; src1_6 = 0; src2_6 = 0; itag6 = 0;
        repeat (2) @(negedge CLK);
        chk("rst_ov", ov, 0);   chk("rst_res", res, 0); chk("rst_tag", otag, 0);
        chk("rst_ill", ill, 0); chk("rst_ir", ir, 1);   chk("rst_ov64", ov6, 0);
        rst_n = 1'b1;
        @(negedge CLK);

        // SLL 50 by 4, latency 2
        drv(3'b000, 32'd50, 5'd4, 4'd5); #1 chk("sll_ir", ir, 1);
        @(negedge CLK); iv = 0; chk("sll_early", ov, 0);
        @(negedge CLK);
        chk("sll_ov", ov, 1); chk("sll_res", res, 800); chk("sll_ill", ill, 0); chk("sll_tag", otag, 5);
        @(negedge CLK); chk("sll_once", ov, 0);

        // back-to-back SRA/ROR/ROL
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drv(b_op[i], b_src[i], b_sh[i], 4'(i + 1)); else iv = 0;
            if (i >= 2) begin
                chk("b2b_ov", ov, 1); chk("b2b_res", res, b_exp[i-2]); chk("b2b_tag", otag, 64'(i - 1));
            end
            @(negedge CLK);
        end
        chk("b2b_end", ov, 0);

        // backpressure with three ops in flight/delivered
        drv(3'b000, 32'd1, 5'd1, 4'd4);          @(negedge CLK);
        drv(3'b011, 32'h8765_4321, 5'd0, 4'd5);  @(negedge CLK);
        drv(3'b000, 32'd3, 5'd31, 4'd6);
        chk("bp_res1", res, 2); chk("bp_tag1", otag, 4);
        @(negedge CLK); iv = 0; ordy = 0; #1;
        for (int j = 0; j < 3; j++) begin
            chk("bp_ov", ov, 1); chk("bp_res2", res, 32'h8765_4321); chk("bp_tag2", otag, 5);
            chk("bp_ir", ir, 0);
            @(negedge CLK);
        end
        ordy = 1; chk("bp_hold", res, 32'h8765_4321);
        @(negedge CLK); chk("bp_ov3", ov, 1); chk("bp_res3", res, 32'h8000_0000); chk("bp_tag3", otag, 6);
        @(negedge CLK); chk("bp_nodup", ov, 0);

        // flush with two in flight and one offered in the flush cycle
        drv(3'b001, 32'hF0, 5'd4, 4'd8); @(negedge CLK);
        drv(3'b100, 32'd1, 5'd1, 4'd9);  @(negedge CLK);
        drv(3'b000, 32'd7, 5'd1, 4'd12); flush = 1; #1 chk("fl_ir", ir, 0);
        @(negedge CLK); flush = 0; iv = 0; chk("fl_ov1", ov, 0);
        @(negedge CLK); chk("fl_noacc", ov, 0);
        drv(3'b001, 32'h100, 5'd8, 4'd10);
        @(negedge CLK); iv = 0;
        @(negedge CLK); chk("fl_ov", ov, 1); chk("fl_res", res, 1); chk("fl_tag", otag, 10);
        @(negedge CLK);

        // reserved op
        drv(3'b010, 32'hFFFF_FFFF, 5'd3, 4'd7);
        @(negedge CLK); iv = 0;
        @(negedge CLK); chk("il_ov", ov, 1); chk("il_res", res, 0); chk("il_ill", ill, 1); chk("il_tag", otag, 7);

        // async reset with ops in flight
        drv(3'b000, 32'h1234, 5'd4, 4'd3); @(negedge CLK);
        drv(3'b001, 32'hFF00, 5'd8, 4'd2); @(negedge CLK);
        iv = 0; chk("mr_pre", res, 32'h12340);
        rst_n = 0; #1;
        chk("mr_ov", ov, 0); chk("mr_res", res, 0); chk("mr_tag", otag, 0); chk("mr_ill", ill, 0);
        chk("mr_ir", ir, 1);
        @(negedge CLK); rst_n = 1;
        @(negedge CLK); chk("mr_post1", ov, 0);
        @(negedge CLK); chk("mr_post2", ov, 0);

        // 64-bit, 3 stages: word mode and wide ops back-to-back
        for (int i = 0; i < N6 + 3; i++) begin
            if (i < N6) drv6(w_op[i], w_wd[i], w_src[i], w_sh[i], 4'(i)); else iv6 = 0;
            if (i >= 3) begin
                chk("w64_ov", ov6, 1); chk("w64_res", res6, w_exp[i-3]); chk("w64_tag", otag6, 64'(i - 3));
                chk("w64_ill", ill6, 0);
            end
            @(negedge CLK);
        end
        chk("w64_end", ov6, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
